// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file writeback path.
package regfile_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    // One pending register-file write: destination and value.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order FIFO of writeback entries that holds memory results waiting
// for the register-file write port. DEPTH must be a power of two, so the
// pointers wrap simply by overflowing.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  wb_entry_t              wdata,
    output wb_entry_t              rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t          mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    // Next pointers and occupancy; simultaneous push and pop leaves count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Entry storage carries no reset; occupancy decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Pointer and occupancy state, cleared by reset so buffered results are dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/regfile_writeback.sv
// Writeback arbiter for the register file's single write port.
// ALU results take priority, then buffered memory results, then a memory
// result arriving this cycle. A scoreboard tracks destinations of
// outstanding long-latency ops for decode hazard checks.
// Optional macro RF_BYPASS_EN adds read-data forwarding from the write port.
module regfile_writeback #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alu_valid,
    input  logic [4:0]             alu_rd,
    input  logic [XLEN-1:0]        alu_data,
    input  logic                   mem_valid,
    output logic                   mem_ready,
    input  logic [4:0]             mem_rd,
    input  logic [XLEN-1:0]        mem_data,
    input  logic                   issue_valid,
    input  logic [4:0]             issue_rd,
    input  logic [4:0]             rs1,
    input  logic [4:0]             rs2,
    output logic                   pend1,
    output logic                   pend2,
    output logic                   WE3,
    output logic [4:0]             A3,
    output logic [XLEN-1:0]        WD3,
    output logic [$clog2(DEPTH):0] fifo_count
`ifdef RF_BYPASS_EN
   ,input  logic [4:0]             A1,
    input  logic [4:0]             A2,
    input  logic [XLEN-1:0]        RD1,
    input  logic [XLEN-1:0]        RD2,
    output logic [XLEN-1:0]        RD1_fwd,
    output logic [XLEN-1:0]        RD2_fwd
`endif
);

    import regfile_pkg::*;

    logic            fifo_full, fifo_empty;
    logic            fifo_push, fifo_pop;
    logic            mem_acc;
    wb_entry_t       push_entry, head_entry;

    logic            sel_valid, sel_mem;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;

    logic                WE3_q, WE3_d;
    logic [4:0]          A3_q, A3_d;
    logic [XLEN-1:0]     WD3_q, WD3_d;
    logic                src_mem_q, src_mem_d;
    logic [NUM_REGS-1:0] pending_q, pending_d;

    // mem_ready looks only at registered occupancy, never at this cycle's pop.
    assign mem_ready  = rst && !fifo_full;
    assign mem_acc    = mem_valid && mem_ready;
    assign push_entry = '{rd: mem_rd, data: mem_data};

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (push_entry),
        .rdata (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Write-port arbitration: ALU, then FIFO head, then a direct memory result.
    // A memory result bypasses the FIFO only when nothing else wants the port.
    always_comb begin
        sel_valid = 1'b0;
        sel_mem   = 1'b0;
        sel_rd    = '0;
        sel_data  = '0;
        fifo_push = 1'b0;
        fifo_pop  = 1'b0;
        if (alu_valid) begin
            sel_valid = 1'b1;
            sel_rd    = alu_rd;
            sel_data  = alu_data;
            fifo_push = mem_acc;
        end else if (!fifo_empty) begin
            sel_valid = 1'b1;
            sel_mem   = 1'b1;
            sel_rd    = head_entry.rd;
            sel_data  = head_entry.data;
            fifo_pop  = 1'b1;
            fifo_push = mem_acc;
        end else if (mem_acc) begin
            sel_valid = 1'b1;
            sel_mem   = 1'b1;
            sel_rd    = mem_rd;
            sel_data  = mem_data;
        end
    end

    // Next write-port state; a selected result for x0 is consumed without a write.
    always_comb begin
        WE3_d     = sel_valid && (sel_rd != '0);
        A3_d      = WE3_d ? sel_rd : A3_q;
        WD3_d     = WE3_d ? sel_data : WD3_q;
        src_mem_d = WE3_d && sel_mem;
    end

    // Scoreboard: a launched memory write clears its rd; a new issue sets it and wins a tie.
    always_comb begin
        pending_d = pending_q;
        if (WE3_q && src_mem_q) begin
            pending_d[A3_q] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0)) begin
            pending_d[issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // Registered write port and scoreboard; reset discards any in-flight write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            WE3_q     <= 1'b0;
            A3_q      <= '0;
            WD3_q     <= '0;
            src_mem_q <= 1'b0;
            pending_q <= '0;
        end else begin
            WE3_q     <= WE3_d;
            A3_q      <= A3_d;
            WD3_q     <= WD3_d;
            src_mem_q <= src_mem_d;
            pending_q <= pending_d;
        end
    end

    assign WE3   = WE3_q;
    assign A3    = A3_q;
    assign WD3   = WD3_q;
    assign pend1 = pending_q[rs1] && (rs1 != '0);
    assign pend2 = pending_q[rs2] && (rs2 != '0);

`ifdef RF_BYPASS_EN
    // Forward the write landing this cycle, which the register file cannot yet return.
    assign RD1_fwd = (WE3_q && (A3_q == A1) && (A1 != '0)) ? WD3_q : RD1;
    assign RD2_fwd = (WE3_q && (A3_q == A2) && (A2 != '0)) ? WD3_q : RD2;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback. Expected register-file writes are
// queued as stimulus is driven and checked in order whenever WE3 is high.
module tb_regfile_writeback;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  rs1, rs2;
    logic        pend1, pend2;
    logic        WE3;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic [2:0]  fifo_count;
`ifdef RF_BYPASS_EN
    logic [4:0]  A1, A2;
    logic [31:0] RD1, RD2, RD1_fwd, RD2_fwd;
`endif

    int total = 0;
    int bad   = 0;
    logic [36:0] exp_q[$];

    regfile_writeback #(.XLEN(32), .DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .pend1       (pend1),
        .pend2       (pend2),
        .WE3         (WE3),
        .A3          (A3),
        .WD3         (WD3),
        .fifo_count  (fifo_count)
`ifdef RF_BYPASS_EN
       ,.A1          (A1),
        .A2          (A2),
        .RD1         (RD1),
        .RD2         (RD2),
        .RD1_fwd     (RD1_fwd),
        .RD2_fwd     (RD2_fwd)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every register-file write must be the next expected one.
    always @(negedge clk) begin
        if (WE3 === 1'b1) begin
            total++;
            assert (exp_q.size() > 0) else begin
                bad++;
                $error("FAIL unexpected_write observed=%0h_%0h expected=none", A3, WD3);
            end
            if (exp_q.size() > 0) begin
                logic [36:0] e;
                e = exp_q.pop_front();
                total++;
                assert ({A3, WD3} === e) else begin
                    bad++;
                    $error("FAIL write_order observed=%0h_%0h expected=%0h_%0h",
                           A3, WD3, e[36:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int m;
        int acc_before_drop;
        bit hs;
        logic [4:0] fill_rd [3];

        rst = 1'b0; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
        issue_valid = 1'b0; issue_rd = '0; rs1 = '0; rs2 = '0;
`ifdef RF_BYPASS_EN
        A1 = '0; A2 = '0; RD1 = '0; RD2 = '0;
`endif

        // Reset state
        tick(); tick();
        @(negedge clk);
        chk("rst_we3", 64'(WE3), 64'd0);
        chk("rst_a3", 64'(A3), 64'd0);
        chk("rst_wd3", 64'(WD3), 64'd0);
        chk("rst_count", 64'(fifo_count), 64'd0);
        chk("rst_ready", 64'(mem_ready), 64'd0);
        tick(); rst = 1'b1;
        @(negedge clk);
        chk("ready_after_release", 64'(mem_ready), 64'd1);

        // ALU write, then ALU result for x0
        tick(); alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        exp_q.push_back({5'd5, 32'hDEADBEEF});
        tick(); alu_valid = 1'b0;
        @(negedge clk);
        chk("alu_we3", 64'(WE3), 64'd1);
        chk("alu_a3", 64'(A3), 64'd5);
        chk("alu_wd3", 64'(WD3), 64'hDEADBEEF);
        tick(); alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234;
        tick(); alu_valid = 1'b0;
        @(negedge clk);
        chk("x0_no_write", 64'(WE3), 64'd0);

        // Long op on rd 7 and its scoreboard lifetime
        tick(); issue_valid = 1'b1; issue_rd = 5'd7; rs1 = 5'd7; rs2 = 5'd7;
        tick(); issue_valid = 1'b0;
        @(negedge clk);
        chk("pend1_set", 64'(pend1), 64'd1);
        chk("pend2_set", 64'(pend2), 64'd1);
        tick(); mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h1234;
        exp_q.push_back({5'd7, 32'h1234});
        @(negedge clk);
        chk("mem_ready_idle", 64'(mem_ready), 64'd1);
        chk("pend1_before_wb", 64'(pend1), 64'd1);
        tick(); mem_valid = 1'b0;
        @(negedge clk);
        chk("mem_direct_we3", 64'(WE3), 64'd1);
        chk("pend1_in_wb_cycle", 64'(pend1), 64'd1);
        tick();
        @(negedge clk);
        chk("pend1_cleared", 64'(pend1), 64'd0);

        // Set and clear of rd 9 in the same cycle: set wins
        tick(); issue_valid = 1'b1; issue_rd = 5'd9;
        tick(); issue_valid = 1'b0; mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h9999;
        exp_q.push_back({5'd9, 32'h9999});
        tick(); mem_valid = 1'b0; issue_valid = 1'b1; issue_rd = 5'd9;
        @(negedge clk);
        chk("rd9_launch_a3", 64'(A3), 64'd9);
        tick(); issue_valid = 1'b0; rs1 = 5'd9;
        @(negedge clk);
        chk("rd9_set_wins", 64'(pend1), 64'd1);
        tick(); mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h9A;
        exp_q.push_back({5'd9, 32'h9A});
        tick(); mem_valid = 1'b0;
        tick();
        @(negedge clk);
        chk("rd9_cleared", 64'(pend1), 64'd0);

        // ALU busy 6 cycles while memory offers rd 1..5: FIFO fills, then drains in order
        m = 1;
        acc_before_drop = -1;
        for (int k = 0; k < 12; k++) begin
            tick();
            alu_valid = (k < 6);
            alu_rd    = 5'(20 + k);
            alu_data  = 32'hA000 + 32'(k);
            if (k < 6) exp_q.push_back({5'(20 + k), 32'hA000 + 32'(k)});
            if (k == 6) begin
                for (int j = 1; j <= 5; j++) exp_q.push_back({5'(j), 32'h100 + 32'(j)});
            end
            mem_valid = (m <= 5);
            mem_rd    = 5'(m);
            mem_data  = 32'h100 + 32'(m);
            @(negedge clk);
            if (k == 4) chk("fifo_full_count", 64'(fifo_count), 64'd4);
            if (k == 6) chk("ready_ignores_pop", 64'(mem_ready), 64'd0);
            if (mem_valid && !mem_ready && acc_before_drop < 0) acc_before_drop = m - 1;
            hs = mem_valid && mem_ready;
            if (hs) m++;
        end
        tick(); mem_valid = 1'b0; alu_valid = 1'b0;
        chk("accepts_before_full", 64'(acc_before_drop), 64'd4);
        chk("all_mem_accepted", 64'(m), 64'd6);
        repeat (4) tick();
        chk("drain_empty_queue", 64'(exp_q.size()), 64'd0);

        // Reset with three buffered results and pending {3,4}
        fill_rd[0] = 5'd3; fill_rd[1] = 5'd4; fill_rd[2] = 5'd6;
        issue_valid = 1'b1; issue_rd = 5'd3;
        tick(); issue_rd = 5'd4;
        tick(); issue_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hBAD;
        for (int i = 0; i < 3; i++) begin
            mem_valid = 1'b1; mem_rd = fill_rd[i]; mem_data = 32'h300 + 32'(i);
            tick();
        end
        mem_valid = 1'b0; rs1 = 5'd3; rs2 = 5'd4;
        @(negedge clk);
        chk("pre_rst_count", 64'(fifo_count), 64'd3);
        chk("pre_rst_pend1", 64'(pend1), 64'd1);
        chk("pre_rst_pend2", 64'(pend2), 64'd1);
        tick(); rst = 1'b0;
        tick();
        @(negedge clk);
        chk("mid_rst_count", 64'(fifo_count), 64'd0);
        chk("mid_rst_we3", 64'(WE3), 64'd0);
        chk("mid_rst_pend1", 64'(pend1), 64'd0);
        chk("mid_rst_pend2", 64'(pend2), 64'd0);
        chk("mid_rst_ready", 64'(mem_ready), 64'd0);
        tick(); rst = 1'b1; alu_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 64'(mem_ready), 64'd1);
        repeat (6) tick();

`ifdef RF_BYPASS_EN
        // Forwarding from the write port
        alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hA5A5A5A5;
        exp_q.push_back({5'd10, 32'hA5A5A5A5});
        tick(); alu_valid = 1'b0;
        A1 = 5'd10; RD1 = 32'h0; A2 = 5'd11; RD2 = 32'h22;
        @(negedge clk);
        chk("fwd_rd1_hit", 64'(RD1_fwd), 64'hA5A5A5A5);
        chk("fwd_rd2_miss", 64'(RD2_fwd), 64'h22);
        A1 = 5'd0; RD1 = 32'h11;
        #1;
        chk("fwd_x0", 64'(RD1_fwd), 64'h11);
        repeat (2) tick();
`endif

        chk("final_empty_queue", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Writeback arbiter and write-port driver for the 32-entry register file. Merges single-cycle ALU results and variable-latency memory/long-op results into the register file's single write port (WE3/A3/WD3), buffering memory results in a small FIFO when the port is busy. Keeps a scoreboard of destination registers with outstanding long-latency ops so that decode can stall on RAW hazards. Sits between the execute/memory stages and the register file.

## Interface
- XLEN, 32, data width
- DEPTH, 4, memory-result FIFO entries, power of 2, ≥2
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-low reset
- alu_valid  in  1  ALU result present this cycle; no backpressure
- alu_rd  in  5  ALU destination register
- alu_data  in  XLEN  ALU result
- mem_valid  in  1  memory/long-op result offered
- mem_ready  out  1  result accepted when mem_valid && mem_ready
- mem_rd  in  5  memory destination register
- mem_data  in  XLEN  memory result
- issue_valid  in  1  long-latency op issued this cycle
- issue_rd  in  5  its destination register
- rs1, rs2  in  5 each  decode source registers
- pend1, pend2  out  1 each  rs1/rs2 has an outstanding long-op write (combinational)
- WE3  out  1  register-file write enable (registered)
- A3  out  5  register-file write address (registered)
- WD3  out  XLEN  register-file write data (registered)
- fifo_count  out  $clog2(DEPTH)+1  FIFO occupancy
- A1, A2  in  5 each  (RF_BYPASS_EN only) register-file read addresses
- RD1, RD2  in  XLEN each  (RF_BYPASS_EN only) raw register-file read data
- RD1_fwd, RD2_fwd  out  XLEN each  (RF_BYPASS_EN only) forwarded read data

## Operation
- Per-cycle write-port selection, priority: ALU > FIFO head > direct memory result.
- mem_ready = !full, where full = (fifo_count == DEPTH). mem_ready is not combinationally dependent on a pop in the same cycle.
- An accepted memory result goes direct to the write port only if alu_valid == 0 and the FIFO is empty. Otherwise it is pushed. Push and pop in the same cycle: occupancy unchanged, order preserved.
- The FIFO is strictly in order. Pointers wrap modulo DEPTH.
- If the selected result has rd == 0, it is consumed and WE3 stays 0 that cycle. x0 is never written.
- Scoreboard pending[31:1]: issue_valid with issue_rd != 0 sets pending[issue_rd]. A memory-sourced result whose write is launched (WE3 registered high) clears pending[rd]. Simultaneous set and clear of the same rd: the set wins.
- pend1 = pending[rs1] && rs1 != 0; likewise pend2.
- Decode must not issue a second long op to an rd that is already pending. Decode must not let an ALU op write an rd that is pending. Both are enforced upstream via pend1/pend2 and an rd check.
- ALU results never touch the scoreboard.

## Timing
- Latency: a result selected in cycle N appears on WE3/A3/WD3 in cycle N+1. The register file captures it at the end of cycle N+1.
- Worst-case memory latency to the write port: 1 + (entries ahead) + (ALU cycles that preempt).
- Reset (rst == 0 at an edge): WE3 = 0, A3 = 0, WD3 = 0, FIFO emptied, fifo_count = 0, pending cleared, mem_ready = 0 while rst is low.
- Reset mid-operation discards buffered results and in-flight writes. The cycle after reset release has mem_ready = 1.
- Continuous alu_valid starves the FIFO. This is permitted; upstream guarantees gaps.
- Full FIFO: mem_ready = 0. mem_valid, mem_rd and mem_data must hold stable until accepted.

## Configuration
- RF_BYPASS_EN defined: the A1/A2/RD1/RD2/RD1_fwd/RD2_fwd ports exist.
  - RDx_fwd = WD3 when WE3 && A3 == Ax && Ax != 0; otherwise RDx_fwd = RDx.
  - This covers the same-cycle write/read window of the register file.
- RF_BYPASS_EN undefined: the bypass ports and logic are absent. Decode must stall one cycle on that window.

## Structure
- Shared package regfile_pkg: XLEN, REG_ADDR_W = 5, NUM_REGS = 32, and a wb_entry_t struct {rd, data}.
- Sub-module wb_fifo: parameterized synchronous FIFO of wb_entry_t with push, pop, full, empty and count. The top level holds the selection logic, the scoreboard, the output registers and the bypass.

## Test plan
- Reset, then alu_valid with rd = 5, data = 0xDEADBEEF in cycle 1 → cycle 2 shows WE3 = 1, A3 = 5, WD3 = 0xDEADBEEF. With alu_rd = 0 instead → WE3 stays 0.
- issue rd = 7, then later mem result rd = 7, data = 0x1234 while the ALU is idle → pend1 = 1 for rs1 = 7 until the WE3 cycle for A3 = 7, and 0 the cycle after.
- alu_valid held high 6 cycles while mem_valid offers rd = 1..5 → mem_ready drops after 4 accepts. Results are then written in order 1, 2, 3, 4, 5 once the ALU is idle.
- Same cycle: issue rd = 9 and a mem write launch for rd = 9 → pending[9] remains 1.
- Assert rst low with 3 FIFO entries and pending = {3, 4} → the next cycle has fifo_count = 0, WE3 = 0, pend flags 0, and no stale writes appear.
- RF_BYPASS_EN: WE3 = 1, A3 = 10, WD3 = 0xA5A5A5A5, A1 = 10, RD1 = 0 → RD1_fwd = 0xA5A5A5A5. With A1 = 0 → RD1_fwd = RD1.
